if_fetch_ctrl: RTL and testbench

//  Instruction-fetch controller; consumer side of the PC register's instruction-address output.

---
 rtl/if_fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction-fetch controller: one outstanding imem read per PC value; pc_valid to inst_valid in 3 cycles on zero-wait memory.
// inst_valid is held until inst_ready, with no new request meanwhile; IF_TIMEOUT_EN adds a response timeout with orphan tracking.
module if_fetch_ctrl #(
   parameter int ADDR_W      = 64,
   parameter int INST_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              pc_valid,
   output logic              pc_advance,
   input  logic              flush,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [INST_W-1:0] mem_resp_data,
   input  logic              mem_resp_err,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_addr,
   output logic [1:0]        inst_fault
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [INST_W-1:0] data_q;
   logic [1:0]        fault_q;
   logic              killed;
   logic              resp_live;
   logic              idle_block;
   logic              timeout;

`ifdef IF_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] cnt;
   logic             orphan;

   // A response to a timed-out request may still arrive; it must never reach the FSM.
   assign resp_live  = mem_resp_valid && !orphan;
   assign idle_block = orphan;
   assign timeout    = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         orphan <= 1'b0;
      end else begin
         if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
         else                 cnt <= '0;
         if (timeout && !flush && !resp_live) orphan <= 1'b1;
         else if (orphan && mem_resp_valid)   orphan <= 1'b0;
      end
   end
`else
   assign resp_live  = mem_resp_valid;
   assign idle_block = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         fault_q <= 2'b00;
         killed  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pc_valid && !flush && !idle_block) begin
                  addr_q <= pc_addr;
                  if (pc_addr[1:0] != 2'b00) begin
                     state   <= S_HOLD;
                     data_q  <= '0;
                     fault_q <= 2'b01;
                  end else begin
                     state  <= S_REQ;
                     killed <= 1'b0;
                  end
               end
            end
            // The request is never withdrawn; a flush only marks it for discard.
            S_REQ: begin
               if (mem_req_ready)  state  <= (flush || killed) ? S_DROP : S_WAIT;
               else if (flush)     killed <= 1'b1;
            end
            S_WAIT: begin
               if (flush) begin
                  state <= resp_live ? S_IDLE : S_DROP;
               end else if (resp_live) begin
                  state   <= S_HOLD;
                  data_q  <= mem_resp_err ? '0 : mem_resp_data;
                  fault_q <= mem_resp_err ? 2'b10 : 2'b00;
               end else if (timeout) begin
                  state   <= S_HOLD;
                  data_q  <= '0;
                  fault_q <= 2'b11;
               end
            end
            S_HOLD: begin
               if (flush || inst_ready) state <= S_IDLE;
            end
            S_DROP: begin
               if (resp_live) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mem_req_valid = (state == S_REQ);
   assign mem_req_addr  = addr_q;
   assign inst_valid    = (state == S_HOLD);
   assign inst_data     = data_q;
   assign inst_addr     = addr_q;
   assign inst_fault    = fault_q;
   assign pc_advance    = inst_valid && inst_ready && !flush;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
`timescale 1ns/1ps
// Bench for if_fetch_ctrl: vector table, hand-written corner sequences, then random traffic against a PC/memory model.
module tb_if_fetch_ctrl;

`ifdef IF_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_addr;
   logic        pc_valid;
   logic        pc_advance;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_addr;
   logic [1:0]  inst_fault;

   int errors = 0;
   int checks = 0;

   if_fetch_ctrl #(.ADDR_W(64), .INST_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_advance(pc_advance),
      .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_addr(inst_addr), .inst_fault(inst_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [63:0] pa;
      logic        fl;
      logic        rr;
      logic        rv;
      logic [31:0] rd;
      logic        re;
      logic        ir;
      logic        e_req;
      logic        e_iv;
      logic        e_adv;
      logic [1:0]  e_flt;
      logic [31:0] e_dat;
      logic [63:0] e_addr;
   } vec_t;

   vec_t tbl[30];

   function automatic vec_t mk(input logic pv, input logic [63:0] pa, input logic fl, input logic rr,
                               input logic rv, input logic [31:0] rd, input logic re, input logic ir,
                               input logic e_req, input logic e_iv, input logic e_adv,
                               input logic [1:0] e_flt, input logic [31:0] e_dat, input logic [63:0] e_addr);
      vec_t v;
      v.pv = pv; v.pa = pa; v.fl = fl; v.rr = rr; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir;
      v.e_req = e_req; v.e_iv = e_iv; v.e_adv = e_adv; v.e_flt = e_flt; v.e_dat = e_dat; v.e_addr = e_addr;
      return v;
   endfunction

   // Memory contents and bus-error map used by the random phase.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0013;
   endfunction

   function automatic logic mem_err(input logic [63:0] a);
      return a[4:2] == 3'b111;
   endfunction

   function automatic logic [63:0] new_target();
      logic [63:0] t;
      t = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
      if (($urandom % 4) == 0) t[1:0] = 2'($urandom % 4);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [63:0] pa, input logic fl, input logic rr,
                        input logic rv, input logic [31:0] rd, input logic re, input logic ir);
      pc_valid = pv; pc_addr = pa; flush = fl; mem_req_ready = rr;
      mem_resp_valid = rv; mem_resp_data = rd; mem_resp_err = re; inst_ready = ir;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a;
      logic [63:0] a2;
      int          accepts;
      logic        seen;
      logic [63:0] pc;
      int          resp_cnt;
      logic [63:0] resp_addr;
      logic        prev_stall;
      logic [63:0] prev_req_addr;
      logic        prev_hold;
      logic [31:0] prev_data;
      logic [63:0] prev_iaddr;
      logic [1:0]  prev_flt;
      int          handshakes;

      rst = 1'b0;
      drive(0, 64'h0, 0, 0, 0, 32'h0, 0, 0);
      #2;
      chk("rst_req_vld", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_inst_vld", inst_valid, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_addr", inst_addr, 0);
      chk("rst_fault", inst_fault, 0);
      chk("rst_adv", pc_advance, 0);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();

      tbl[0]  = mk(1, 64'h8000_0000, 0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[1]  = mk(0, 64'h8000_0000, 0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[2]  = mk(0, 64'h8000_0000, 0, 1, 1, 32'h13,        0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[3]  = mk(0, 64'h8000_0000, 0, 1, 0, 32'h0,         0, 1, 0, 1, 1, 2'b00, 32'h13, 64'h8000_0000);
      tbl[4]  = mk(0, 64'h8000_0000, 0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[5]  = mk(1, 64'h8000_0002, 0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[6]  = mk(0, 64'h8000_0002, 0, 1, 0, 32'h0,         0, 0, 0, 1, 0, 2'b01, 32'h0, 64'h8000_0002);
      tbl[7]  = mk(0, 64'h8000_0002, 0, 1, 0, 32'h0,         0, 1, 0, 1, 1, 2'b01, 32'h0, 64'h8000_0002);
      tbl[8]  = mk(1, 64'h8000_0004, 0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[9]  = mk(0, 64'h8000_0004, 0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[10] = mk(0, 64'h8000_0004, 1, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[11] = mk(0, 64'h8000_0004, 0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[12] = mk(0, 64'h8000_0004, 0, 1, 1, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[13] = mk(1, 64'h8000_0008, 0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[14] = mk(0, 64'h8000_0008, 0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[15] = mk(0, 64'h8000_0008, 0, 1, 1, 32'h00A0_0093, 0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[16] = mk(0, 64'h8000_0008, 0, 1, 0, 32'h0,         0, 1, 0, 1, 1, 2'b00, 32'h00A0_0093, 64'h8000_0008);
      tbl[17] = mk(1, 64'h10,        0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[18] = mk(0, 64'h10,        0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[19] = mk(0, 64'h10,        0, 1, 1, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[20] = mk(0, 64'h10,        0, 1, 0, 32'h0,         0, 1, 0, 1, 1, 2'b10, 32'h0, 64'h10);
      tbl[21] = mk(1, 64'h20,        0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[22] = mk(0, 64'h20,        0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[23] = mk(0, 64'h20,        0, 1, 1, 32'h1234,      0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[24] = mk(0, 64'h20,        1, 1, 0, 32'h0,         0, 1, 0, 1, 0, 2'b00, 32'h1234, 64'h20);
      tbl[25] = mk(0, 64'h20,        0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[26] = mk(1, 64'h30,        0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[27] = mk(0, 64'h30,        1, 1, 0, 32'h0,         0, 1, 1, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[28] = mk(0, 64'h30,        0, 1, 1, 32'h55,        0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);
      tbl[29] = mk(0, 64'h30,        0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 2'b00, 32'h0, 64'h0);

      for (int i = 0; i < 30; i++) begin
         drive(tbl[i].pv, tbl[i].pa, tbl[i].fl, tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].ir);
         @(negedge clk);
         chk($sformatf("vec%0d_req_vld", i), mem_req_valid, tbl[i].e_req);
         chk($sformatf("vec%0d_inst_vld", i), inst_valid, tbl[i].e_iv);
         chk($sformatf("vec%0d_adv", i), pc_advance, tbl[i].e_adv);
         if (tbl[i].e_iv) begin
            chk($sformatf("vec%0d_fault", i), inst_fault, tbl[i].e_flt);
            chk($sformatf("vec%0d_data", i), inst_data, tbl[i].e_dat);
            chk($sformatf("vec%0d_addr", i), inst_addr, tbl[i].e_addr);
         end
         next_cycle();
      end

      // Request back-pressure: address must stay latched even though pc_addr moves.
      a = 64'h8000_0040;
      accepts = 0;
      drive(1, a, 0, 0, 0, 32'h0, 0, 1);
      next_cycle();
      for (int i = 0; i < 6; i++) begin
         drive(0, 64'h1234_5678_0000, 0, (i == 5), 0, 32'h0, 0, 1);
         @(negedge clk);
         chk($sformatf("t3_req_vld%0d", i), mem_req_valid, 1);
         chk($sformatf("t3_req_addr%0d", i), mem_req_addr, a);
         if (mem_req_valid && mem_req_ready) accepts++;
         next_cycle();
      end
      drive(0, 64'h0, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) accepts++;
      chk("t3_no_reissue", mem_req_valid, 0);
      next_cycle();
      drive(0, 64'h0, 0, 1, 1, 32'h33, 0, 1);
      next_cycle();
      drive(0, 64'h0, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      chk("t3_accepts", accepts, 1);
      chk("t3_inst_data", inst_data, 32'h33);
      chk("t3_inst_addr", inst_addr, a);
      chk("t3_adv", pc_advance, 1);
      next_cycle();

      // Decode stall for 10 cycles with pc_valid kept high.
      a = 64'h8000_0080;
      drive(1, a, 0, 1, 0, 32'h0, 0, 0);
      next_cycle();
      drive(0, a, 0, 1, 0, 32'h0, 0, 0);
      next_cycle();
      drive(0, a, 0, 1, 1, 32'h77, 0, 0);
      next_cycle();
      for (int i = 0; i < 10; i++) begin
         drive(1, 64'h8000_0100, 0, 1, 0, 32'h0, 0, 0);
         @(negedge clk);
         chk($sformatf("t5_iv%0d", i), inst_valid, 1);
         chk($sformatf("t5_data%0d", i), inst_data, 32'h77);
         chk($sformatf("t5_addr%0d", i), inst_addr, a);
         chk($sformatf("t5_fault%0d", i), inst_fault, 0);
         chk($sformatf("t5_req%0d", i), mem_req_valid, 0);
         chk($sformatf("t5_adv%0d", i), pc_advance, 0);
         next_cycle();
      end
      drive(0, 64'h0, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      chk("t5_adv_accept", pc_advance, 1);
      next_cycle();
      @(negedge clk);
      chk("t5_adv_after", pc_advance, 0);
      chk("t5_iv_after", inst_valid, 0);
      next_cycle();

      // Asynchronous reset while waiting for a response.
      a = 64'h8000_0200;
      drive(1, a, 0, 1, 0, 32'h0, 0, 1);
      next_cycle();
      drive(0, a, 0, 1, 0, 32'h0, 0, 1);
      next_cycle();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_req_vld", mem_req_valid, 0);
      chk("arst_req_addr", mem_req_addr, 0);
      chk("arst_inst_vld", inst_valid, 0);
      chk("arst_inst_addr", inst_addr, 0);
      chk("arst_adv", pc_advance, 0);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();
      a = 64'h8000_0204;
      drive(1, a, 0, 1, 0, 32'h0, 0, 1);
      next_cycle();
      drive(0, a, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      chk("arst_idle_fetch", mem_req_valid, 1);
      chk("arst_fetch_addr", mem_req_addr, a);
      next_cycle();
      drive(0, a, 0, 1, 1, 32'h99, 0, 1);
      next_cycle();
      drive(0, a, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      chk("arst_fetch_data", inst_data, 32'h99);
      next_cycle();

`ifdef IF_TIMEOUT_EN
      // Timeout, orphaned late response, then a clean fetch.
      a = 64'h8000_0300;
      drive(1, a, 0, 1, 0, 32'h0, 0, 0);
      next_cycle();
      drive(0, a, 0, 1, 0, 32'h0, 0, 0);
      next_cycle();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("t6_wait%0d", k), inst_valid, 0);
         next_cycle();
      end
      drive(0, a, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      chk("t6_to_iv", inst_valid, 1);
      chk("t6_to_fault", inst_fault, 2'b11);
      chk("t6_to_data", inst_data, 0);
      chk("t6_to_addr", inst_addr, a);
      next_cycle();
      a2 = 64'h8000_0304;
      for (int k = 0; k < 2; k++) begin
         drive(1, a2, 0, 1, 0, 32'h0, 0, 1);
         @(negedge clk);
         chk($sformatf("t6_orphan_block%0d", k), mem_req_valid, 0);
         next_cycle();
      end
      drive(1, a2, 0, 1, 1, 32'hBAD0_BAD0, 0, 1);
      @(negedge clk);
      chk("t6_late_resp_iv", inst_valid, 0);
      next_cycle();
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         drive(1, a2, 0, 1, 0, 32'h0, 0, 1);
         @(negedge clk);
         if (mem_req_valid) begin
            seen = 1'b1;
            chk("t6_refetch_addr", mem_req_addr, a2);
         end
         next_cycle();
      end
      chk("t6_refetch_seen", seen, 1);
      drive(0, a2, 0, 1, 1, 32'h0000_0013, 0, 1);
      next_cycle();
      drive(0, a2, 0, 1, 0, 32'h0, 0, 1);
      @(negedge clk);
      chk("t6_refetch_iv", inst_valid, 1);
      chk("t6_refetch_data", inst_data, 32'h13);
      chk("t6_refetch_fault", inst_fault, 0);
      next_cycle();
`endif

      // Random traffic: the PC model only moves on advance or on a flush redirect.
      pc = 64'h8000_1000;
      resp_cnt = -1;
      resp_addr = 64'h0;
      prev_stall = 1'b0;
      prev_req_addr = 64'h0;
      prev_hold = 1'b0;
      prev_data = 32'h0;
      prev_iaddr = 64'h0;
      prev_flt = 2'b00;
      handshakes = 0;
      for (int c = 0; c < 3000; c++) begin
         logic pv_r, fl_r, rr_r, rv_r, ir_r, hs;
         pv_r = ($urandom % 8) != 0;
         fl_r = ($urandom % 16) == 0;
         rr_r = 1'($urandom % 2);
         ir_r = ($urandom % 3) != 0;
         rv_r = (resp_cnt == 0);
         drive(pv_r, pc, fl_r, rr_r, rv_r, mem_word(resp_addr), mem_err(resp_addr), ir_r);
         @(negedge clk);
         hs = inst_valid && ir_r && !fl_r;
         chk("rnd_adv", pc_advance, hs);
         if (prev_stall) begin
            chk("rnd_req_held", mem_req_valid, 1);
            chk("rnd_req_addr_stable", mem_req_addr, prev_req_addr);
         end
         if (prev_hold) begin
            chk("rnd_hold_iv", inst_valid, 1);
            chk("rnd_hold_data", inst_data, prev_data);
            chk("rnd_hold_addr", inst_addr, prev_iaddr);
            chk("rnd_hold_fault", inst_fault, prev_flt);
         end
         if (mem_req_valid && rr_r) begin
            chk("rnd_single_outstanding", resp_cnt < 0, 1);
            chk("rnd_req_aligned", mem_req_addr[1:0], 0);
         end
         if (hs) begin
            handshakes++;
            chk("rnd_inst_addr", inst_addr, pc);
            if (pc[1:0] != 2'b00) begin
               chk("rnd_fault_mis", inst_fault, 2'b01);
               chk("rnd_data_mis", inst_data, 0);
            end else if (mem_err(pc)) begin
               chk("rnd_fault_err", inst_fault, 2'b10);
               chk("rnd_data_err", inst_data, 0);
            end else begin
               chk("rnd_fault_ok", inst_fault, 2'b00);
               chk("rnd_data_ok", inst_data, mem_word(pc));
            end
         end
         prev_stall = mem_req_valid && !rr_r;
         prev_req_addr = mem_req_addr;
         prev_hold = inst_valid && !ir_r && !fl_r;
         prev_data = inst_data;
         prev_iaddr = inst_addr;
         prev_flt = inst_fault;
         if (rv_r) resp_cnt = -1;
         if (mem_req_valid && rr_r) begin
            resp_addr = mem_req_addr;
            resp_cnt = $urandom_range(3, 1);
         end
         if (resp_cnt > 0) resp_cnt--;
         if (hs) pc = (($urandom % 8) == 0) ? new_target() : pc + 64'd4;
         else if (fl_r) pc = new_target();
         next_cycle();
      end
      chk("rnd_handshakes_min", handshakes >= 100, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
